// File: rtl/counter_bank_pkg.sv
// Shared op encoding and overflow-mode constants for the counter bank.
package counter_bank_pkg;

    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_INCR = 2'b01,
        OP_DECR = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    localparam int MODE_WRAP  = 0;
    localparam int MODE_CLAMP = 1;

endpackage

// File: rtl/counter_bank_alu.sv
// Combinational next-value and overflow logic for one counter channel.
module counter_bank_alu
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  op_e              op,
    input  logic [WIDTH-1:0] step,
    input  logic             sat,
    output logic [WIDTH-1:0] next,
    output logic             ovf
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra top bit is the carry (add) or borrow (subtract).
    function automatic logic [WIDTH-1:0] wrapOrClamp(input logic [WIDTH:0] raw,
                                                     input logic clampOn,
                                                     input logic upward);
        if (clampOn && raw[WIDTH])
            return upward ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        return raw[WIDTH-1:0];
    endfunction

    assign sum  = {1'b0, value} + {1'b0, step};
    assign diff = {1'b0, value} - {1'b0, step};

    always_comb begin
        next = value;
        ovf  = 1'b0;
        case (op)
            OP_INCR: begin
                next = wrapOrClamp(sum, sat, 1'b1);
                ovf  = sum[WIDTH];
            end
            OP_DECR: begin
                next = wrapOrClamp(diff, sat, 1'b0);
                ovf  = diff[WIDTH];
            end
            OP_LOAD: next = step;
            default: ;
        endcase
    end

endmodule

// File: rtl/counter_bank.sv
// Bank of independent counters driven by a single command port plus per-channel auto-increment.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int SATURATE = 0,
    localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    input  logic [1:0]                cmd_op,
    input  logic [CHW-1:0]            cmd_ch,
    input  logic [WIDTH-1:0]          cmd_data,
    input  logic [CHANNELS-1:0]       auto_en,
    output logic                      rsp_valid,
    output logic [WIDTH-1:0]          rsp_value,
    output logic                      rsp_ovf,
    output logic [CHANNELS*WIDTH-1:0] count_flat,
    output logic [CHANNELS-1:0]       ovf_sticky
);

    logic                sat;
    logic                cmdHit_p0;
    logic [CHANNELS-1:0] chSel_p0;
    op_e                 chOp_p0   [CHANNELS];
    logic [WIDTH-1:0]    chStep_p0 [CHANNELS];
    logic [WIDTH-1:0]    chNext_p0 [CHANNELS];
    logic                chOvf_p0  [CHANNELS];
    logic [WIDTH-1:0]    cnt       [CHANNELS];
    logic [WIDTH-1:0]    rspValue_p0;
    logic                rspOvf_p0;

    assign sat       = (SATURATE == MODE_CLAMP);
    assign cmdHit_p0 = cmd_valid && ({1'b0, cmd_ch} < (CHW+1)'(CHANNELS));

    // Stage p0: a command on a channel overrides (and drops) that channel's auto step.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            chSel_p0[i]  = cmdHit_p0 && (int'(cmd_ch) == i);
            chOp_p0[i]   = OP_READ;
            chStep_p0[i] = '0;
            if (chSel_p0[i]) begin
                chOp_p0[i]   = op_e'(cmd_op);
                chStep_p0[i] = cmd_data;
            end else if (auto_en[i]) begin
                chOp_p0[i]   = OP_INCR;
                chStep_p0[i] = WIDTH'(1);
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : gChan
        counter_bank_alu #(
            .WIDTH(WIDTH)
        ) uAlu (
            .value(cnt[g]),
            .op   (chOp_p0[g]),
            .step (chStep_p0[g]),
            .sat  (sat),
            .next (chNext_p0[g]),
            .ovf  (chOvf_p0[g])
        );
        assign count_flat[g*WIDTH +: WIDTH] = cnt[g];
    end

    always_comb begin
        rspValue_p0 = '0;
        rspOvf_p0   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chSel_p0[i]) begin
                rspValue_p0 = chNext_p0[i];
                rspOvf_p0   = chOvf_p0[i];
            end
        end
    end

    // Stage p1: counters, sticky flags and the response all register on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
            ovf_sticky <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= chNext_p0[i];
                if (chSel_p0[i] && chOp_p0[i] == OP_LOAD)
                    ovf_sticky[i] <= 1'b0;
                else if (chOvf_p0[i])
                    ovf_sticky[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_value <= '0;
            rsp_ovf   <= 1'b0;
        end else begin
            rsp_valid <= cmdHit_p0;
            if (cmdHit_p0) begin
                rsp_value <= rspValue_p0;
                rsp_ovf   <= rspOvf_p0;
            end
        end
    end

endmodule

// File: tb/tb_counter_bank.sv
// Drives a wrap-mode 4-channel bank and a clamp-mode 3-channel bank with shared stimulus.
module tb_counter_bank;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_ch;
    logic [7:0]  cmd_data;
    logic [3:0]  auto_en;

    logic        rspValidW, rspOvfW;
    logic [7:0]  rspValueW;
    logic [31:0] countW;
    logic [3:0]  stickyW;
    logic        rspValidC, rspOvfC;
    logic [7:0]  rspValueC;
    logic [23:0] countC;
    logic [2:0]  stickyC;

    int checks = 0;
    int errors = 0;

    int mCnt      [2][4];
    bit mSticky   [2][4];
    bit mRspValid [2];
    int mRspVal   [2];
    bit mRspOvf   [2];

    counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(0)) dutW (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
        .cmd_data(cmd_data), .auto_en(auto_en), .rsp_valid(rspValidW), .rsp_value(rspValueW),
        .rsp_ovf(rspOvfW), .count_flat(countW), .ovf_sticky(stickyW)
    );

    counter_bank #(.WIDTH(8), .CHANNELS(3), .SATURATE(1)) dutC (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
        .cmd_data(cmd_data), .auto_en(auto_en[2:0]), .rsp_valid(rspValidC), .rsp_value(rspValueC),
        .rsp_ovf(rspOvfC), .count_flat(countC), .ovf_sticky(stickyC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic void applyOp(input int v, input int op, input int s, input bit sat,
                                    output int r, output bit o);
        o = 1'b0;
        r = v;
        case (op)
            1: begin
                r = v + s;
                if (r > 255) begin o = 1'b1; r = sat ? 255 : r - 256; end
            end
            2: begin
                r = v - s;
                if (r < 0) begin o = 1'b1; r = sat ? 0 : r + 256; end
            end
            3: r = s;
            default: ;
        endcase
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mRspValid[d] = 1'b0;
            mRspVal[d]   = 0;
            mRspOvf[d]   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                mCnt[d][i]    = 0;
                mSticky[d][i] = 1'b0;
            end
        end
    endtask

    task automatic modelStep(input int d);
        int nch;
        bit sat;
        bit hit;
        int r;
        bit o;
        nch = (d == 0) ? 4 : 3;
        sat = (d == 1);
        hit = cmd_valid && (int'(cmd_ch) < nch);
        mRspValid[d] = hit;
        for (int i = 0; i < nch; i++) begin
            if (hit && int'(cmd_ch) == i) begin
                applyOp(mCnt[d][i], int'(cmd_op), int'(cmd_data), sat, r, o);
                mRspVal[d] = r;
                mRspOvf[d] = o;
                if (cmd_op == 2'b11) mSticky[d][i] = 1'b0;
                else if (o) mSticky[d][i] = 1'b1;
                mCnt[d][i] = r;
            end else if (auto_en[i]) begin
                applyOp(mCnt[d][i], 1, 1, sat, r, o);
                mCnt[d][i] = r;
                if (o) mSticky[d][i] = 1'b1;
            end
        end
    endtask

    function automatic int dutCnt(input int d, input int i);
        if (d == 0) return int'(countW[i*8 +: 8]);
        return int'(countC[i*8 +: 8]);
    endfunction

    function automatic int dutSticky(input int d, input int i);
        if (d == 0) return int'(stickyW[i]);
        return int'(stickyC[i]);
    endfunction

    // Compare process: every cycle, one time unit after the rising edge.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            int nch;
            nch = (d == 0) ? 4 : 3;
            check("rsp_valid", d, (d == 0) ? int'(rspValidW) : int'(rspValidC), int'(mRspValid[d]));
            if (mRspValid[d]) begin
                check("rsp_value", d, (d == 0) ? int'(rspValueW) : int'(rspValueC), mRspVal[d]);
                check("rsp_ovf", d, (d == 0) ? int'(rspOvfW) : int'(rspOvfC), int'(mRspOvf[d]));
            end
            for (int i = 0; i < nch; i++) begin
                check($sformatf("count[%0d]", i), d, dutCnt(d, i), mCnt[d][i]);
                check($sformatf("ovf_sticky[%0d]", i), d, dutSticky(d, i), int'(mSticky[d][i]));
            end
        end
    end

    task automatic cycle(input bit v, input logic [1:0] op, input logic [1:0] ch,
                         input logic [7:0] data, input logic [3:0] ae);
        cmd_valid = v;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_data  = data;
        auto_en   = ae;
        modelStep(0);
        modelStep(1);
        @(posedge clk);
        #2;
    endtask

    task automatic checkAllZero();
        check("rst rsp_valid", 0, int'(rspValidW), 0);
        check("rst rsp_value", 0, int'(rspValueW), 0);
        check("rst rsp_ovf", 0, int'(rspOvfW), 0);
        check("rst count_flat", 0, int'(countW), 0);
        check("rst ovf_sticky", 0, int'(stickyW), 0);
        check("rst rsp_valid", 1, int'(rspValidC), 0);
        check("rst rsp_value", 1, int'(rspValueC), 0);
        check("rst count_flat", 1, int'(countC), 0);
        check("rst ovf_sticky", 1, int'(stickyC), 0);
    endtask

    // Asserts reset mid-cycle, whatever command is on the bus, then releases it idle.
    task automatic doReset();
        rst = 1'b1;
        modelReset();
        #1;
        checkAllZero();
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        auto_en   = '0;
        rst       = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_ch    = 2'b00;
        cmd_data  = 8'd0;
        auto_en   = 4'b0000;
        modelReset();
        #1;
        checkAllZero();
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;

        // Wrap overflow: 250 + 10 -> 4 (wrap) / 255 (clamp).
        cycle(1, 2'b11, 2'd1, 8'd250, 4'b0000);
        cycle(1, 2'b01, 2'd1, 8'd10, 4'b0000);
        check("wrap incr value", 0, int'(rspValueW), 4);
        check("wrap incr ovf", 0, int'(rspOvfW), 1);
        check("wrap sticky1", 0, int'(stickyW[1]), 1);
        check("clamp incr value", 1, int'(rspValueC), 255);

        // Underflow: 3 - 5 -> 0 (clamp) / 254 (wrap); zero step is a no-op.
        cycle(1, 2'b11, 2'd0, 8'd3, 4'b0000);
        cycle(1, 2'b10, 2'd0, 8'd5, 4'b0000);
        check("clamp decr value", 1, int'(rspValueC), 0);
        check("clamp decr ovf", 1, int'(rspOvfC), 1);
        check("wrap decr value", 0, int'(rspValueW), 254);
        cycle(1, 2'b01, 2'd0, 8'd0, 4'b0000);
        check("zero step value", 1, int'(rspValueC), 0);
        check("zero step ovf", 1, int'(rspOvfC), 0);
        check("zero step ovf", 0, int'(rspOvfW), 0);

        // Collision: command on ch2 drops its auto step; ch3 still auto-advances.
        cycle(1, 2'b11, 2'd2, 8'd7, 4'b0000);
        cycle(1, 2'b11, 2'd3, 8'd20, 4'b0000);
        check("out of range rsp_valid", 1, int'(rspValidC), 0);
        cycle(1, 2'b01, 2'd2, 8'd5, 4'b1100);
        check("collision ch2", 0, int'(countW[23:16]), 12);
        check("collision ch3", 0, int'(countW[31:24]), 21);
        check("collision ch2", 1, int'(countC[23:16]), 12);

        // Range check on the 3-channel bank.
        cycle(1, 2'b01, 2'd3, 8'd1, 4'b0000);
        check("range rsp_valid", 1, int'(rspValidC), 0);
        check("range counters", 1, int'(countC), 32'h000CFF00);

        // LOAD clears the sticky flag.
        cycle(1, 2'b11, 2'd1, 8'd9, 4'b0000);
        check("load clears sticky", 0, int'(stickyW), 1);
        check("load clears sticky1", 1, int'(stickyC[1]), 0);
        check("load value", 0, int'(rspValueW), 9);

        // Auto overflow sets sticky; a LOAD with auto active on that channel clears it.
        cycle(1, 2'b11, 2'd2, 8'd255, 4'b0100);
        cycle(0, 2'b00, 2'd0, 8'd0, 4'b0100);
        check("auto wrap ch2", 0, int'(countW[23:16]), 0);
        check("auto sticky2", 0, int'(stickyW[2]), 1);
        check("auto clamp ch2", 1, int'(countC[23:16]), 255);
        cycle(1, 2'b11, 2'd2, 8'd5, 4'b0100);
        check("load vs auto sticky2", 0, int'(stickyW[2]), 0);
        check("load vs auto ch2", 1, int'(countC[23:16]), 5);

        // Reset between two back-to-back INCRs.
        cycle(1, 2'b01, 2'd0, 8'd1, 4'b0000);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_ch    = 2'd0;
        cmd_data  = 8'd1;
        doReset();
        cycle(0, 2'b00, 2'd0, 8'd0, 4'b0000);
        check("no stale rsp", 0, int'(rspValidW), 0);
        check("no stale rsp", 1, int'(rspValidC), 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] data;
            if ($urandom_range(0, 299) == 0) begin
                cmd_valid = 1'b1;
                doReset();
            end
            data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  data, 4'($urandom & $urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
